mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Memory-side responder for the CPU's external address/data bus: a 2^ADDR_W x DATA_W RAM answering CPU read/write strobes on addr_bus and tri-state data_bus.
- Four-phase strobe/ready handshake with programmable wait states. Drives data_bus only while acknowledging a read.
- Side-band loader port preloads program/data while the bus is idle. Instantiated in the machine top level opposite the cpu.

Parameters:
- ADDR_W, 8, address width; memory depth = 2^ADDR_W.
- DATA_W, 8, data bus width.
- WAIT_STATES, 1, extra cycles between request capture and ready; range 0..15.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- addr_bus  in  ADDR_W  CPU address
- data_bus  inout  DATA_W  shared data bus; driven only in ACK of a read, else 'z
- rd_en  in  1  CPU read strobe, held until ready seen
- wr_en  in  1  CPU write strobe, held until ready seen
- ready  out  1  access complete; held high until strobe released
- bus_err  out  1  one-cycle pulse on illegal request (rd_en && wr_en)
- ld_en  in  1  loader write enable
- ld_addr  in  ADDR_W  loader address
- ld_data  in  DATA_W  loader data

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset: state=IDLE, ready=0, bus_err=0, data_bus released ('z) immediately, wait counter=0, latched addr/data=0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, ACK, ERR.
- IDLE:
  - ld_en=1: write mem[ld_addr]=ld_data at the edge; loader has priority, and any CPU strobe that cycle is re-sampled next cycle.
  - Else rd_en XOR wr_en: latch addr_bus, latch data_bus (write), latch direction. Go to WAIT (cnt=WAIT_STATES-1), or directly to ACK if WAIT_STATES=0.
  - Else rd_en && wr_en: bus_err=1 for one cycle, go to ERR.
- WAIT:
  - cnt decrements each cycle; at cnt=0, go to ACK.
  - Strobe dropped during WAIT: abort to IDLE next edge, with no write commit and no ready.
  - ld_en is ignored outside IDLE.
- Transition into ACK: write commits mem[addr_q]=wdata_q; read captures rdata_q=mem[addr_q].
- ACK:
  - ready=1 and, for reads, data_bus=rdata_q.
  - Stay while the latched strobe is high. Strobe low: go to IDLE next edge, and ready/drive drop at that edge.
  - Address changes during WAIT/ACK have no effect (latched).
- ERR: stay until rd_en=0 and wr_en=0, then IDLE. No memory access.
- Latency: strobe first sampled at edge k → ready high after edge k+1+WAIT_STATES.
- Minimum back-to-back spacing: one IDLE cycle between accesses.
- Read-after-write to the same address returns the new data, because the commit precedes the next capture.
- ld_en outside IDLE: dropped silently; the loader is used only while the CPU is held in reset or idle.
- Address wrap: none needed; the full 2^ADDR_W space is backed.

Decomposition:
- Package mem_bus_pkg: state enum typedef (IDLE, WAIT, ACK, ERR), bus width localparams, strobe encoding constants.
- Sub-module mem_array_sp: single-port RAM with synchronous write and combinational read. Write port is muxed between loader and CPU commit; they never collide, because loader writes occur only in IDLE.
- Top holds FSM, wait counter, latches and the tri-state driver.

Test Plan:
- Loader writes 0xA5 to 0x10, then CPU read of 0x10 with WAIT_STATES=1 → ready high 2 edges after first strobe sample; data_bus=0xA5 while ready; 'z after strobe drop.
- CPU write 0x3C to 0xFF, then read 0xFF → read returns 0x3C; data_bus is 'z throughout the write.
- WAIT_STATES=0 read → ready after 1 edge. WAIT_STATES=3 → ready after 4 edges.
- rd_en=wr_en=1 at address 0x20 → bus_err pulses exactly 1 cycle, no ready, mem[0x20] unchanged; FSM returns to IDLE only after both strobes low.
- Write to 0x40 with strobe dropped mid-WAIT (WAIT_STATES=3) → no ready; later read of 0x40 returns the prior value.
- rst asserted during a read ACK → data_bus 'z and ready=0 asynchronously; after release, mem contents intact (re-read returns the stored value).

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-side bus responder.
package mem_bus_pkg;

   localparam int BUS_ADDR_W = 8;
   localparam int BUS_DATA_W = 8;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK,
      ERR
   } state_t;

   // Strobe pair encoded as {rd_en, wr_en}
   localparam logic [1:0] STB_NONE = 2'b00;
   localparam logic [1:0] STB_WR   = 2'b01;
   localparam logic [1:0] STB_RD   = 2'b10;
   localparam logic [1:0] STB_BOTH = 2'b11;

endpackage

// File: rtl/mem_bus_responder_mem_array_sp.sv
// Single-port RAM: synchronous write, combinational read at the same address.
module mem_array_sp
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W = BUS_ADDR_W,
   parameter int DATA_W = BUS_DATA_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wdata;
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_bus_responder.sv
// RAM responder for the CPU address/data bus: strobe/ready handshake with
// programmable wait states, tri-state read data and an idle-time loader port.
module mem_bus_responder
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W      = BUS_ADDR_W,
   parameter int DATA_W      = BUS_DATA_W,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr_bus,
   inout  wire  [DATA_W-1:0] data_bus,
   input  logic              rd_en,
   input  logic              wr_en,
   output logic              ready,
   output logic              bus_err,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data
);

   localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              is_rd_q, is_rd_d;
   logic              ready_q, ready_d;
   logic              drive_q, drive_d;
   logic              bus_err_q, bus_err_d;

   logic [1:0]        stb;
   logic              stb_held;
   logic              commit;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   assign stb      = {rd_en, wr_en};
   assign stb_held = is_rd_q ? rd_en : wr_en;

   // In IDLE the RAM port follows the loader or the live bus so that a
   // zero-wait access can commit in the same edge that captures it.
   assign mem_addr  = (state_q == IDLE) ? (ld_en ? ld_addr : addr_bus) : addr_q;
   assign mem_wdata = (state_q == IDLE) ? (ld_en ? ld_data : data_bus) : wdata_q;
   assign mem_we    = ((state_q == IDLE) && ld_en) || (commit && !is_rd_d);

   mem_array_sp #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      is_rd_d   = is_rd_q;
      ready_d   = 1'b0;
      drive_d   = 1'b0;
      bus_err_d = 1'b0;
      commit    = 1'b0;

      case (state_q)
         IDLE: begin
            if (ld_en) begin
               state_d = IDLE;
            end else if (stb == STB_RD || stb == STB_WR) begin
               addr_d  = addr_bus;
               is_rd_d = (stb == STB_RD);
               cnt_d   = WS_LOAD;
               if (stb == STB_WR) wdata_d = data_bus;
               if (WAIT_STATES == 0) begin
                  state_d = ACK;
                  commit  = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end else if (stb == STB_BOTH) begin
               bus_err_d = 1'b1;
               state_d   = ERR;
            end
         end
         WAIT: begin
            if (!stb_held) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d = ACK;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ACK: begin
            // ready and the bus drive are registered, so they rise one edge
            // after entry and fall on the edge that sees the strobe released.
            if (stb_held) begin
               ready_d = 1'b1;
               drive_d = is_rd_q;
            end else begin
               state_d = IDLE;
            end
         end
         ERR: begin
            if (stb == STB_NONE) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (commit && is_rd_d) rdata_d = mem_rdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         is_rd_q   <= 1'b0;
         ready_q   <= 1'b0;
         drive_q   <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         is_rd_q   <= is_rd_d;
         ready_q   <= ready_d;
         drive_q   <= drive_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign data_bus = drive_q ? rdata_q : {DATA_W{1'bz}};
   assign ready    = ready_q;
   assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: three instances (0, 1 and 3 wait states)
// checked each cycle against an edge-indexed transaction model.
module tb_mem_bus_responder;

   logic       clk;
   logic       rst;
   logic [2:0] rd_a, wr_a, ld_a;
   logic [7:0] addr_a    [3];
   logic [7:0] drv_a     [3];
   logic [7:0] ld_addr_a [3];
   logic [7:0] ld_data_a [3];
   wire  [2:0] ready_w;
   wire  [2:0] berr_w;
   wire  [7:0] bus_obs   [3];

   int n_chk = 0;
   int n_err = 0;

   // model state
   int         edge_n = 0;
   logic [7:0] mem_m   [3][256];
   logic [2:0] m_busy, m_rd, m_err, m_ready, m_berr;
   logic [7:0] m_addr  [3];
   logic [7:0] m_wd    [3];
   logic [7:0] m_rdata [3];
   int         m_start [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      wire [7:0] dbus;
      assign dbus       = rd_a[g] ? 8'hzz : drv_a[g];
      assign bus_obs[g] = dbus;
      mem_bus_responder #(
         .ADDR_W      (8),
         .DATA_W      (8),
         .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .addr_bus (addr_a[g]),
         .data_bus (dbus),
         .rd_en    (rd_a[g]),
         .wr_en    (wr_a[g]),
         .ready    (ready_w[g]),
         .bus_err  (berr_w[g]),
         .ld_en    (ld_a[g]),
         .ld_addr  (ld_addr_a[g]),
         .ld_data  (ld_data_a[g])
      );
   end

   function automatic int ws_of(input int i);
      case (i)
         0:       return 0;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   task automatic check(input string name, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // The access is complete at data-commit edge start+WS; ready is seen
   // from edge start+1+WS until the edge that samples the strobe low.
   task automatic model_commit(input int i);
      if (m_rd[i]) m_rdata[i] = mem_m[i][m_addr[i]];
      else         mem_m[i][m_addr[i]] = m_wd[i];
   endtask

   task automatic model_step();
      edge_n++;
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_busy[i]  = 1'b0;
            m_err[i]   = 1'b0;
            m_ready[i] = 1'b0;
            m_berr[i]  = 1'b0;
            m_rd[i]    = 1'b0;
         end else begin
            m_berr[i] = 1'b0;
            if (m_err[i]) begin
               if (!rd_a[i] && !wr_a[i]) m_err[i] = 1'b0;
            end else if (m_busy[i]) begin
               if (!(m_rd[i] ? rd_a[i] : wr_a[i])) m_busy[i] = 1'b0;
               else if (edge_n == m_start[i] + ws_of(i)) model_commit(i);
            end else if (ld_a[i]) begin
               mem_m[i][ld_addr_a[i]] = ld_data_a[i];
            end else if (rd_a[i] != wr_a[i]) begin
               m_busy[i]  = 1'b1;
               m_rd[i]    = rd_a[i];
               m_addr[i]  = addr_a[i];
               m_wd[i]    = drv_a[i];
               m_start[i] = edge_n;
               if (ws_of(i) == 0) model_commit(i);
            end else if (rd_a[i] && wr_a[i]) begin
               m_err[i]  = 1'b1;
               m_berr[i] = 1'b1;
            end
            m_ready[i] = m_busy[i] && (edge_n >= m_start[i] + 1 + ws_of(i));
         end
      end
   endtask

   task automatic compare_step();
      logic dut_drv;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("ready[%0d]", i), 32'(ready_w[i]), 32'(m_ready[i]));
         check($sformatf("bus_err[%0d]", i), 32'(berr_w[i]), 32'(m_berr[i]));
         dut_drv = m_ready[i] && m_rd[i];
         if (dut_drv && rd_a[i])
            check($sformatf("bus_read[%0d]", i), 32'(bus_obs[i]), 32'(m_rdata[i]));
         else if (!dut_drv && !rd_a[i])
            check($sformatf("bus_released[%0d]", i), 32'(bus_obs[i]), 32'(drv_a[i]));
      end
   endtask

   task automatic load(input int i, input logic [7:0] a, input logic [7:0] d);
      @(posedge clk); #2;
      ld_a[i] = 1'b1; ld_addr_a[i] = a; ld_data_a[i] = d;
      @(posedge clk); #2;
      ld_a[i] = 1'b0;
   endtask

   // One CPU access; exp_edges counts clock edges from strobe assertion
   // until ready is first seen high.
   task automatic access(input int i, input bit is_rd, input logic [7:0] a, input logic [7:0] wd,
                         input int exp_edges, input logic [7:0] exp_rd, input bit with_ld);
      int edges;
      bit got;
      @(posedge clk); #2;
      addr_a[i] = a;
      if (with_ld) begin
         ld_a[i] = 1'b1; ld_addr_a[i] = a; ld_data_a[i] = wd;
      end
      if (is_rd) rd_a[i] = 1'b1;
      else begin
         wr_a[i] = 1'b1; drv_a[i] = wd;
      end
      edges = 0;
      got   = 1'b0;
      while (!got && edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         ld_a[i] = 1'b0;
         if (edges >= 1 + int'(with_ld)) begin
            addr_a[i] = ~a;
            if (!is_rd) drv_a[i] = ~wd;
         end
         got = ready_w[i];
      end
      check($sformatf("latency[%0d]", i), edges, exp_edges);
      if (is_rd) check($sformatf("rdata[%0d]", i), 32'(bus_obs[i]), 32'(exp_rd));
      @(posedge clk); #2;
      rd_a[i] = 1'b0; wr_a[i] = 1'b0; drv_a[i] = 8'h00;
      @(posedge clk); #1;
      check($sformatf("ready_drop[%0d]", i), 32'(ready_w[i]), 0);
   endtask

   task automatic run_tests();
      int pulses;
      int rdy;
      int edges;

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_ready[%0d]", i), 32'(ready_w[i]), 0);
         check($sformatf("rst_bus_err[%0d]", i), 32'(berr_w[i]), 0);
         check($sformatf("rst_bus[%0d]", i), 32'(bus_obs[i]), 0);
      end
      @(posedge clk); #2;
      rst = 1'b0;

      // loader then read, read-after-write, loader racing a read strobe
      load(1, 8'h10, 8'hA5);
      access(1, 1'b1, 8'h10, 8'h00, 3, 8'hA5, 1'b0);
      access(1, 1'b0, 8'hFF, 8'h3C, 3, 8'h00, 1'b0);
      access(1, 1'b1, 8'hFF, 8'h00, 3, 8'h3C, 1'b0);
      access(1, 1'b1, 8'h30, 8'h11, 4, 8'h11, 1'b1);

      // zero wait states
      load(0, 8'h10, 8'hC3);
      access(0, 1'b1, 8'h10, 8'h00, 2, 8'hC3, 1'b0);
      access(0, 1'b0, 8'h22, 8'h81, 2, 8'h00, 1'b0);
      access(0, 1'b1, 8'h22, 8'h00, 2, 8'h81, 1'b0);

      // three wait states, then a write abandoned mid-wait
      load(2, 8'h40, 8'h77);
      access(2, 1'b1, 8'h40, 8'h00, 5, 8'h77, 1'b0);
      @(posedge clk); #2;
      addr_a[2] = 8'h40; wr_a[2] = 1'b1; drv_a[2] = 8'h99;
      @(posedge clk);
      @(posedge clk); #2;
      wr_a[2] = 1'b0; drv_a[2] = 8'h00;
      rdy = 0;
      repeat (6) begin
         @(negedge clk);
         if (ready_w[2]) rdy++;
      end
      check("abort_ready", rdy, 0);
      access(2, 1'b1, 8'h40, 8'h00, 5, 8'h77, 1'b0);

      // both strobes at once
      load(1, 8'h20, 8'h5E);
      @(posedge clk); #2;
      addr_a[1] = 8'h20; rd_a[1] = 1'b1; wr_a[1] = 1'b1; drv_a[1] = 8'hFF;
      pulses = 0;
      rdy    = 0;
      repeat (6) begin
         @(negedge clk);
         if (berr_w[1]) pulses++;
         if (ready_w[1]) rdy++;
      end
      check("err_pulses", pulses, 1);
      @(posedge clk); #2;
      wr_a[1] = 1'b0; drv_a[1] = 8'h00;
      repeat (3) begin
         @(negedge clk);
         if (ready_w[1] || berr_w[1]) rdy++;
      end
      @(posedge clk); #2;
      rd_a[1] = 1'b0;
      @(negedge clk);
      if (ready_w[1]) rdy++;
      check("err_no_ready", rdy, 0);
      access(1, 1'b1, 8'h20, 8'h00, 3, 8'h5E, 1'b0);

      // reset while a read is being acknowledged
      @(posedge clk); #2;
      addr_a[1] = 8'h10; rd_a[1] = 1'b1;
      edges = 0;
      while (!ready_w[1] && edges < 20) begin
         @(negedge clk);
         edges++;
      end
      check("pre_rst_ready", 32'(ready_w[1]), 1);
      check("pre_rst_bus", 32'(bus_obs[1]), 32'h A5);
      #1 rst = 1'b1;
      #1 check("rst_async_ready", 32'(ready_w[1]), 0);
      rd_a[1] = 1'b0;
      #1 check("rst_async_bus", 32'(bus_obs[1]), 0);
      @(posedge clk); #2;
      rst = 1'b0;
      access(1, 1'b1, 8'h10, 8'h00, 3, 8'hA5, 1'b0);
      repeat (3) @(posedge clk);
   endtask

   initial begin
      rst  = 1'b1;
      rd_a = '0;
      wr_a = '0;
      ld_a = '0;
      for (int i = 0; i < 3; i++) begin
         addr_a[i]    = 8'h00;
         drv_a[i]     = 8'h00;
         ld_addr_a[i] = 8'h00;
         ld_data_a[i] = 8'h00;
      end
      fork
         run_tests();
         forever begin
            @(posedge clk);
            model_step();
         end
         forever begin
            @(negedge clk);
            if (!rst) compare_step();
         end
         begin
            #200000;
            n_chk++;
            n_err++;
            $display("FAIL watchdog: got timeout, required completion");
         end
      join_any
      disable fork;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
